branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter: SHADOW_DEPTH, 2, number of younger instructions discarded after a taken branch (legal 1..7).
REQ-002 Parameter: CNT_W, 16, width of the statistics counters.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  decoded branch presented.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 pc  in  32  address of the branch instruction.
REQ-009 rs1_data, rs2_data  in  32 each  register operands already read for rs1/rs2.
REQ-010 imm  in  13  branch offset from decode, bit 0 always 0, two's complement.
REQ-011 branch_control  in  3  funct3 from decode.
REQ-012 out_valid  out  1  resolved result held in output register.
REQ-013 out_ready  in  1  downstream consumes result.
REQ-014 taken  out  1  branch condition true.
REQ-015 target  out  32  redirect PC: pc+4 if not taken, else branch target.
REQ-016 misaligned  out  1  taken target has target[1:0] != 0.
REQ-017 illegal  out  1  branch_control is 010 or 011.
REQ-018 flush  out  1  one-cycle pulse requesting front-end redirect.
REQ-019 branch_count, taken_count  out  CNT_W each  saturating statistics.

Function
REQ-020 Compare: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU; 010/011 -> taken=0, illegal=1.
REQ-021 Branch target = pc + sign_extend(imm) mod 2^32; not-taken target = pc + 4 mod 2^32; wrap-around SHALL NOT be flagged.
REQ-022 misaligned=1 only when taken=1 and target[1:0] != 0; misaligned and illegal results SHALL NOT assert flush.
REQ-023 Acceptance = in_valid && in_ready; results registered, out_valid rises the cycle after acceptance (latency 1).
REQ-024 In state RUN: in_ready = !out_valid || out_ready; back-to-back acceptance SHALL sustain one branch per cycle.
REQ-025 The output register SHALL hold taken/target/misaligned/illegal stable while out_valid && !out_ready.
REQ-026 out_valid falls after out_ready handshake unless a new input is accepted in the same cycle.
REQ-027 FSM states RUN and SQUASH; reset -> RUN.
REQ-028 RUN -> SQUASH on acceptance of a taken, aligned, legal branch; flush=1 in the following cycle only, coincident with out_valid rising.
REQ-029 On that transition the squash counter loads SHADOW_DEPTH.
REQ-030 In SQUASH: in_ready=1 regardless of output state; each accepted input is discarded (output register, flags and counters untouched) and decrements the counter.
REQ-031 SQUASH -> RUN in the cycle the counter decrements to 0; the next input is processed normally.
REQ-032 SQUASH cycles with in_valid=0 SHALL NOT decrement the counter.
REQ-033 The output register SHALL drain normally via out_ready during SQUASH.
REQ-034 branch_count increments per non-discarded acceptance; taken_count increments when that branch is taken; both saturate at all-ones.
REQ-035 Illegal branches count in branch_count, never in taken_count.

Reset
REQ-036 On rst=1 at a clock edge: out_valid=0, taken=0, target=0, misaligned=0, illegal=0, flush=0, counters=0, FSM=RUN, squash counter=0.
REQ-037 Reset mid-SQUASH or with out_valid=1 and out_ready=0 SHALL discard all state; in_ready=1 the cycle after reset.

Verification
REQ-038 BEQ pc=0x100, rs1=rs2=5, imm=0x010 -> next cycle out_valid=1, taken=1, target=0x110, flush=1 for one cycle.
REQ-039 BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1; BLTU with the same operands -> taken=0, target=pc+4.
REQ-040 Taken branch then 3 back-to-back inputs, SHADOW_DEPTH=2 -> first two discarded, third resolved; branch_count=2.
REQ-041 pc=0xFFFFFFFC, not taken -> target=0x00000000; taken with imm=0x1FFE (-2) -> misaligned=1, flush=0.
REQ-042 out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0, outputs stable; out_ready=1 with in_valid=1 -> new result next cycle, no bubble.
REQ-043 branch_control=010 -> illegal=1, taken=0, taken_count unchanged; rst asserted during SQUASH -> RUN, counters 0 next cycle.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Purpose : resolves conditional branches (compare, target, alignment, legality) and
//           squashes the SHADOW_DEPTH younger instructions that follow a redirecting branch.
// Latency : 1 cycle from acceptance to out_valid; flush pulses together with out_valid.
// Backpressure: in_ready = !out_valid || out_ready while resolving; always 1 while squashing.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid / in_ready           - decoded branch handshake
//   pc, rs1_data, rs2_data        - branch address and register operands
//   imm, branch_control           - 13-bit signed offset (bit 0 = 0), funct3
//   out_valid / out_ready         - resolved result handshake
//   taken, target, misaligned,
//   illegal                       - resolved result (held while stalled)
//   flush                         - one-cycle front-end redirect request
//   branch_count, taken_count     - saturating statistics

module branch_resolve_unit #(
    parameter int SHADOW_DEPTH = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      pc,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic [12:0]      imm,
    input  logic [2:0]       branch_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [31:0]      target,
    output logic             misaligned,
    output logic             illegal,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        misaligned;
        logic        illegal;
    } res_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0]       SQ_LOAD = 3'(SHADOW_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_nxt;
    logic [2:0]  sq_cnt, sq_cnt_nxt;
    res_t        res_q, res_c;

    logic        accept;
    logic        process_in;
    logic        cond;
    logic        legal;
    logic        redirect;
    logic [31:0] imm_sext;
    logic [31:0] br_target;
    logic [31:0] seq_target;

    // ------------------------------------------------------------------
    // Combinational resolution of the presented branch
    // ------------------------------------------------------------------
    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        unique case (branch_control)
            F3_BEQ:  cond = (rs1_data == rs2_data);
            F3_BNE:  cond = (rs1_data != rs2_data);
            F3_BLT:  cond = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  cond = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: cond = (rs1_data <  rs2_data);
            F3_BGEU: cond = (rs1_data >= rs2_data);
            default: begin
                cond  = 1'b0;
                legal = 1'b0;
            end
        endcase
    end

    // Address arithmetic wraps modulo 2^32 by construction; no overflow flag.
    assign imm_sext   = {{19{imm[12]}}, imm};
    assign br_target  = pc + imm_sext;
    assign seq_target = pc + 32'd4;

    always_comb begin
        res_c            = '0;
        res_c.illegal    = !legal;
        res_c.taken      = legal && cond;
        res_c.target     = res_c.taken ? br_target : seq_target;
        res_c.misaligned = res_c.taken && (res_c.target[1:0] != 2'b00);
    end

    // Only a clean taken branch redirects the front end; faulting branches
    // are reported through the flags and leave the pipeline alone.
    assign redirect = res_c.taken && !res_c.misaligned && !res_c.illegal;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // While squashing, inputs are swallowed without touching the output
    // register, so they never need to wait for the consumer.
    assign in_ready   = (state == SQUASH) ? 1'b1 : (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign process_in = accept && (state == RUN);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            sq_cnt <= 3'd0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sq_cnt_nxt = sq_cnt;
        unique case (state)
            RUN: begin
                if (process_in && redirect) begin
                    state_nxt  = SQUASH;
                    sq_cnt_nxt = SQ_LOAD;
                end
            end
            SQUASH: begin
                // Idle cycles do not consume shadow slots.
                if (accept) begin
                    sq_cnt_nxt = sq_cnt - 3'd1;
                    if (sq_cnt == 3'd1) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt  = RUN;
                sq_cnt_nxt = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res_q     <= '0;
            flush     <= 1'b0;
        end else begin
            flush <= process_in && redirect;
            if (process_in) begin
                out_valid <= 1'b1;
                res_q     <= res_c;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign taken      = res_q.taken;
    assign target     = res_q.target;
    assign misaligned = res_q.misaligned;
    assign illegal    = res_q.illegal;

    // ------------------------------------------------------------------
    // Saturating statistics (discarded shadow instructions are not counted)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (process_in) begin
            if (branch_count != '1) begin
                branch_count <= branch_count + CNT_ONE;
            end
            if (res_c.taken && (taken_count != '1)) begin
                taken_count <= taken_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Purpose : directed self-checking bench for branch_resolve_unit.
// Latency : checks results one cycle after acceptance.
// Backpressure: exercises out_ready stalls and squash-mode acceptance.

module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [12:0] imm;
    logic [2:0]  branch_control;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic [31:0] target;
    logic        misaligned;
    logic        illegal;
    logic        flush;
    logic [15:0] branch_count;
    logic [15:0] taken_count;

    int checks   = 0;
    int failures = 0;

    branch_resolve_unit #(
        .SHADOW_DEPTH(2),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pc(pc),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .imm(imm),
        .branch_control(branch_control),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .taken(taken),
        .target(target),
        .misaligned(misaligned),
        .illegal(illegal),
        .flush(flush),
        .branch_count(branch_count),
        .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b, input logic [12:0] i);
        in_valid       = v;
        branch_control = f3;
        pc             = p;
        rs1_data       = a;
        rs2_data       = b;
        imm            = i;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 13'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (taken !== 1'b0 || misaligned !== 1'b0 || illegal !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b%0b%0b exp=0000", taken, misaligned, illegal, flush); end
        checks++; if (target !== 32'h0) begin failures++; $display("FAIL reset_target got=%0h exp=0", target); end
        checks++; if (branch_count !== 16'd0 || taken_count !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_count, taken_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_beq_flush();
        drive(1'b1, 3'b000, 32'h100, 32'd5, 32'd5, 13'h010);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL beq_out_valid got=%0h exp=1", out_valid); end
        checks++; if (taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%0h exp=1", taken); end
        checks++; if (target !== 32'h110) begin failures++; $display("FAIL beq_target got=%0h exp=110", target); end
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL beq_flush got=%0h exp=1", flush); end
        checks++; if (branch_count !== 16'd1 || taken_count !== 16'd1) begin failures++; $display("FAIL beq_counts got=%0d/%0d exp=1/1", branch_count, taken_count); end
        // Idle squash cycle: flush must drop, output drains, squash slots kept.
        tick();
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL beq_flush_pulse got=%0h exp=0", flush); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL beq_drain got=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL beq_squash_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_squash_back_to_back();
        // Two shadow slots still pending; these would be taken if processed.
        drive(1'b1, 3'b000, 32'h200, 32'd7, 32'd7, 13'h040);
        tick();
        checks++; if (out_valid !== 1'b0 || branch_count !== 16'd1) begin failures++; $display("FAIL squash_disc1 got=v%0h c%0d exp=v0 c1", out_valid, branch_count); end
        drive(1'b1, 3'b000, 32'h300, 32'd7, 32'd7, 13'h040);
        tick();
        checks++; if (out_valid !== 1'b0 || branch_count !== 16'd1 || flush !== 1'b0) begin failures++; $display("FAIL squash_disc2 got=v%0h c%0d f%0h exp=v0 c1 f0", out_valid, branch_count, flush); end
        // BLTU with -1 vs 1: unsigned compare false.
        drive(1'b1, 3'b110, 32'h400, 32'hFFFF_FFFF, 32'd1, 13'h020);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || taken !== 1'b0) begin failures++; $display("FAIL bltu_result got=v%0h t%0h exp=v1 t0", out_valid, taken); end
        checks++; if (target !== 32'h404) begin failures++; $display("FAIL bltu_target got=%0h exp=404", target); end
        checks++; if (branch_count !== 16'd2 || taken_count !== 16'd1) begin failures++; $display("FAIL squash_counts got=%0d/%0d exp=2/1", branch_count, taken_count); end
    endtask

    task automatic test_blt_signed();
        drive(1'b1, 3'b100, 32'h500, 32'hFFFF_FFFF, 32'd1, 13'h040);
        tick();
        in_valid = 1'b0;
        checks++; if (taken !== 1'b1 || target !== 32'h540) begin failures++; $display("FAIL blt_result got=t%0h %0h exp=t1 540", taken, target); end
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL blt_flush got=%0h exp=1", flush); end
    endtask

    task automatic test_wrap_misaligned();
        drive(1'b1, 3'b001, 32'h0, 32'd0, 32'd1, 13'h0);
        tick();
        tick();
        // Not taken at top of address space wraps to 0.
        drive(1'b1, 3'b000, 32'hFFFF_FFFC, 32'd1, 32'd2, 13'h010);
        tick();
        checks++; if (out_valid !== 1'b1 || taken !== 1'b0 || target !== 32'h0 || misaligned !== 1'b0) begin failures++; $display("FAIL wrap_result got=v%0h t%0h %0h m%0h exp=v1 t0 0 m0", out_valid, taken, target, misaligned); end
        // imm = -2 gives a halfword-aligned target.
        drive(1'b1, 3'b000, 32'h100, 32'd3, 32'd3, 13'h1FFE);
        tick();
        in_valid = 1'b0;
        checks++; if (taken !== 1'b1 || target !== 32'h0FE) begin failures++; $display("FAIL misal_target got=t%0h %0h exp=t1 fe", taken, target); end
        checks++; if (misaligned !== 1'b1 || flush !== 1'b0) begin failures++; $display("FAIL misal_flags got=m%0h f%0h exp=m1 f0", misaligned, flush); end
        checks++; if (branch_count !== 16'd5 || taken_count !== 16'd3) begin failures++; $display("FAIL misal_counts got=%0d/%0d exp=5/3", branch_count, taken_count); end
        // Misaligned branch must not have started a squash.
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL misal_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        drive(1'b1, 3'b101, 32'h600, 32'd1, 32'd2, 13'h008);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 3'b111, 32'h700, 32'd5, 32'd2, 13'h008);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_pre got=%0h exp=0", in_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || taken !== 1'b0 || target !== 32'h604) begin failures++; $display("FAIL bp_hold%0d got=r%0h v%0h t%0h %0h exp=r0 v1 t0 604", k, in_ready, out_valid, taken, target); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0h exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || taken !== 1'b1 || target !== 32'h708 || flush !== 1'b1) begin failures++; $display("FAIL bp_next got=v%0h t%0h %0h f%0h exp=v1 t1 708 f1", out_valid, taken, target, flush); end
        checks++; if (branch_count !== 16'd7 || taken_count !== 16'd4) begin failures++; $display("FAIL bp_counts got=%0d/%0d exp=7/4", branch_count, taken_count); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 3'b000, 32'h0, 32'd0, 32'd0, 13'h0);
        tick();
        tick();
        drive(1'b1, 3'b010, 32'h800, 32'd3, 32'd3, 13'h008);
        tick();
        checks++; if (illegal !== 1'b1 || taken !== 1'b0 || target !== 32'h804 || flush !== 1'b0) begin failures++; $display("FAIL illegal_result got=i%0h t%0h %0h f%0h exp=i1 t0 804 f0", illegal, taken, target, flush); end
        checks++; if (branch_count !== 16'd8 || taken_count !== 16'd4) begin failures++; $display("FAIL illegal_counts got=%0d/%0d exp=8/4", branch_count, taken_count); end
        drive(1'b1, 3'b000, 32'h900, 32'd1, 32'd2, 13'h008);
        tick();
        in_valid = 1'b0;
        checks++; if (illegal !== 1'b0 || target !== 32'h904 || branch_count !== 16'd9) begin failures++; $display("FAIL b2b_result got=i%0h %0h c%0d exp=i0 904 c9", illegal, target, branch_count); end
    endtask

    task automatic test_reset_in_squash();
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'hA00, 32'd4, 32'd4, 13'h020);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || flush !== 1'b0 || target !== 32'h0) begin failures++; $display("FAIL rsq_state got=v%0h f%0h %0h exp=v0 f0 0", out_valid, flush, target); end
        checks++; if (branch_count !== 16'd0 || taken_count !== 16'd0) begin failures++; $display("FAIL rsq_counts got=%0d/%0d exp=0/0", branch_count, taken_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rsq_in_ready got=%0h exp=1", in_ready); end
        // A squash leftover would discard this; in RUN it is resolved.
        drive(1'b1, 3'b000, 32'hB00, 32'd1, 32'd2, 13'h020);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || target !== 32'hB04 || branch_count !== 16'd1) begin failures++; $display("FAIL rsq_run got=v%0h %0h c%0d exp=v1 b04 c1", out_valid, target, branch_count); end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 13'h0);
        test_reset();
        test_beq_flush();
        test_squash_back_to_back();
        test_blt_signed();
        test_wrap_misaligned();
        test_backpressure();
        test_illegal();
        test_reset_in_squash();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
